// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time from instruction memory,
// holds it in the instruction register for decode, and follows branch redirects.
`timescale 1ns/1ps

module fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        br_valid,
    input  logic [15:0] br_target,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_data,
    output logic [15:0] ir_pc,
    output logic [15:0] fetch_count
);

    // Handshakes: memory accepts when imem_req && imem_gnt; decode accepts when
    // ir_valid && ir_ready. Both sides see the transfer on the same posedge.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic        drop;

    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);
    assign ir_valid  = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            drop        <= 1'b0;
            ir_data     <= 16'h0000;
            ir_pc       <= 16'h0000;
            fetch_count <= 16'h0000;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (br_valid) begin
                        pc <= br_target;
                    end
                    // A grant in the same cycle as a redirect fetched the old pc.
                    if (imem_gnt) begin
                        drop  <= br_valid;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (br_valid) begin
                        pc <= br_target;
                        if (imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        drop <= 1'b0;
                        if (drop) begin
                            state <= FETCH;
                        end else begin
                            ir_data <= imem_rdata;
                            ir_pc   <= pc;
                            pc      <= pc + 16'd1;
                            state   <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (br_valid) begin
                        pc    <= br_target;
                        state <= FETCH;
                    end
                    // A transfer completing alongside a redirect still counts.
                    if (ir_ready) begin
                        fetch_count <= fetch_count + 16'd1;
                        state       <= FETCH;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the driver queues each expected decode transfer,
// a monitor pops and compares on every ir_valid && ir_ready handshake.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        br_valid;
    logic [15:0] br_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_VECTOR(16'h0000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_req(imem_req),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .br_valid(br_valid),
        .br_target(br_target),
        .ir_valid(ir_valid),
        .ir_ready(ir_ready),
        .ir_data(ir_data),
        .ir_pc(ir_pc),
        .fetch_count(fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
    endtask

    // One complete fetch: optional grant stall, optional response latency.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] data,
                         input int gnt_wait, input int rv_wait);
        wait_req();
        chk("fetch_addr", {16'd0, imem_addr}, {16'd0, addr});
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", {16'd0, imem_addr}, {16'd0, addr});
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("wait_no_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rv_wait; i++) begin
            tick();
            chk("wait_no_valid", {31'd0, ir_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        exp_q.push_back({addr, data});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        chk("hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("hold_data", {16'd0, ir_data}, {16'd0, data});
        chk("hold_pc", {16'd0, ir_pc}, {16'd0, addr});
    endtask

    task automatic accept();
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    // Monitor: every decode transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && ir_valid) begin
            chk("no_stale_data", {31'd0, (ir_data == 16'hDEAD || ir_data == 16'hBEEF)}, 32'd0);
            if (ir_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", {ir_pc, ir_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("transfer", {ir_pc, ir_data}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        br_valid    = 1'b0;
        br_target   = 16'h0000;
        ir_ready    = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, 32'h0000);
        chk("rst_count", {16'd0, fetch_count}, 32'd0);
        chk("rst_ir_data", {16'd0, ir_data}, 32'd0);
        chk("rst_ir_pc", {16'd0, ir_pc}, 32'd0);

        // Basic fetch, zero-stall memory
        rst_n = 1'b1;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        fetch(16'h0000, 16'h1234, 0, 0);
        chk("next_addr", {16'd0, imem_addr}, 32'h0001);
        accept();
        chk("count_1", {16'd0, fetch_count}, 32'd1);
        chk("after_accept_req", {31'd0, imem_req}, 32'd1);

        // Decode stall for 5 cycles
        fetch(16'h0001, 16'h5A01, 2, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, ir_valid}, 32'd1);
            chk("stall_data", {16'd0, ir_data}, 32'h5A01);
            chk("stall_pc", {16'd0, ir_pc}, 32'h0001);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_count", {16'd0, fetch_count}, 32'd1);
        end
        accept();
        chk("count_2", {16'd0, fetch_count}, 32'd2);

        // Redirect in WAIT, response arrives a cycle later and is dropped
        wait_req();
        chk("addr_0002", {16'd0, imem_addr}, 32'h0002);
        imem_gnt = 1'b1;
        tick();
        imem_gnt  = 1'b0;
        br_valid  = 1'b1;
        br_target = 16'h0040;
        tick();
        br_valid = 1'b0;
        chk("wait_redirect_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_addr", {16'd0, imem_addr}, 32'h0040);
        chk("drop_valid", {31'd0, ir_valid}, 32'd0);
        fetch(16'h0040, 16'h0C40, 0, 0);
        accept();
        chk("count_3", {16'd0, fetch_count}, 32'd3);

        // Redirect in WAIT coinciding with the response
        wait_req();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        br_valid    = 1'b1;
        br_target   = 16'h0080;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        br_valid    = 1'b0;
        imem_rvalid = 1'b0;
        chk("wr_req", {31'd0, imem_req}, 32'd1);
        chk("wr_addr", {16'd0, imem_addr}, 32'h0080);
        chk("wr_valid", {31'd0, ir_valid}, 32'd0);

        // Redirect in FETCH without grant
        br_valid  = 1'b1;
        br_target = 16'h00A0;
        tick();
        chk("fr_req", {31'd0, imem_req}, 32'd1);
        chk("fr_addr", {16'd0, imem_addr}, 32'h00A0);

        // Redirect in FETCH with grant: granted fetch is stale
        br_target = 16'h00C0;
        imem_gnt  = 1'b1;
        tick();
        br_valid = 1'b0;
        imem_gnt = 1'b0;
        chk("fg_req", {31'd0, imem_req}, 32'd0);
        chk("fg_addr", {16'd0, imem_addr}, 32'h00C0);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        chk("fg_refetch", {31'd0, imem_req}, 32'd1);
        chk("fg_pc_kept", {16'd0, imem_addr}, 32'h00C0);
        chk("fg_valid", {31'd0, ir_valid}, 32'd0);
        fetch(16'h00C0, 16'h7777, 1, 0);
        accept();
        chk("count_4", {16'd0, fetch_count}, 32'd4);

        // pc wrap at FFFF
        br_valid  = 1'b1;
        br_target = 16'hFFFF;
        tick();
        br_valid = 1'b0;
        fetch(16'hFFFF, 16'hF00F, 0, 1);
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);
        accept();
        chk("count_5", {16'd0, fetch_count}, 32'd5);

        // Redirect and accept together in HOLD
        fetch(16'h0000, 16'h1111, 0, 0);
        br_valid  = 1'b1;
        br_target = 16'h0100;
        ir_ready  = 1'b1;
        tick();
        br_valid = 1'b0;
        ir_ready = 1'b0;
        chk("hr_valid", {31'd0, ir_valid}, 32'd0);
        chk("hr_count", {16'd0, fetch_count}, 32'd6);
        chk("hr_req", {31'd0, imem_req}, 32'd1);
        chk("hr_addr", {16'd0, imem_addr}, 32'h0100);

        // Redirect in HOLD without accept: held word discarded, not counted
        fetch(16'h0100, 16'h2222, 0, 0);
        br_valid  = 1'b1;
        br_target = 16'h0200;
        tick();
        br_valid = 1'b0;
        void'(exp_q.pop_back());
        chk("hd_valid", {31'd0, ir_valid}, 32'd0);
        chk("hd_count", {16'd0, fetch_count}, 32'd6);
        chk("hd_addr", {16'd0, imem_addr}, 32'h0200);

        // Stray rvalid in FETCH is ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        chk("stray_req", {31'd0, imem_req}, 32'd1);
        chk("stray_addr", {16'd0, imem_addr}, 32'h0200);
        chk("stray_valid", {31'd0, ir_valid}, 32'd0);

        // Reset with a request in flight; late response lands in BOOT
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("rr_req", {31'd0, imem_req}, 32'd0);
        chk("rr_valid", {31'd0, ir_valid}, 32'd0);
        chk("rr_addr", {16'd0, imem_addr}, 32'h0000);
        chk("rr_count", {16'd0, fetch_count}, 32'd0);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("rr_boot_req", {31'd0, imem_req}, 32'd1);
        chk("rr_boot_addr", {16'd0, imem_addr}, 32'h0000);
        chk("rr_boot_valid", {31'd0, ir_valid}, 32'd0);
        chk("rr_ir_data", {16'd0, ir_data}, 32'h0000);
        fetch(16'h0000, 16'h3333, 2, 1);
        accept();
        chk("count_after_rst", {16'd0, fetch_count}, 32'd1);

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
